adpcm_stream_ctrl: RTL and testbench



---
 rtl/adpcm_stream_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_adpcm_stream_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adpcm_stream_ctrl.sv
// ADPCM capture sequencer: PDM tick and decimation timing, CIC warm-up discard,
// nibble-to-byte packing and a small byte FIFO behind a valid/ready port.
//
// state  | meaning
// IDLE   | waiting for start; bytes already buffered still drain to the consumer
// WARMUP | compressor enabled, encoded nibbles discarded while the CIC settles
// RUN    | nibbles packed high-then-low into bytes and pushed to the FIFO
// DRAIN  | compressor off; flush any half byte, wait for the FIFO to empty
module adpcm_stream_ctrl #(
    parameter int DECIM      = 64,
    parameter int WARMUP     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             pdm_clk_en,
    output logic             dec_strobe,
    output logic             block_enable,
    input  logic             enc_valid,
    input  logic [3:0]       enc_pcm,
    output logic [7:0]       byte_data,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic             overflow,
    output logic             busy
);

    localparam int DEC_W  = $clog2(DECIM);
    localparam int WARM_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_RUN    = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t             state;
    logic [DIV_W-1:0]   div_q;
    logic [DIV_W-1:0]   tick_cnt;
    logic [DEC_W-1:0]   dec_cnt;
    logic [WARM_W-1:0]  warm_cnt;
    logic [3:0]         hold_nib;
    logic               pack_flag;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic               start_go;
    logic               fifo_empty;
    logic               fifo_full;
    logic               pop;
    logic               push_req;
    logic [7:0]         push_byte;
    logic               push_ok;
    logic               drop;

    assign start_go   = (state == S_IDLE) && start;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign pop        = !fifo_empty && byte_ready;

    assign pdm_clk_en = block_enable && (tick_cnt == '0);
    assign dec_strobe = pdm_clk_en && (dec_cnt == '0);

    assign byte_valid = !fifo_empty;
    assign byte_data  = byte_valid ? mem[rd_ptr] : 8'h00;
    assign busy       = (state != S_IDLE);

    // A second nibble in RUN completes a byte; DRAIN flushes a held half byte.
    always_comb begin
        push_req  = 1'b0;
        push_byte = 8'h00;
        if ((state == S_RUN) && enc_valid && pack_flag) begin
            push_req  = 1'b1;
            push_byte = {hold_nib, enc_pcm};
        end else if ((state == S_DRAIN) && pack_flag) begin
            push_req  = 1'b1;
            push_byte = {hold_nib, 4'h0};
        end
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push_req && (!fifo_full || pop);
    assign drop    = push_req && fifo_full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            block_enable <= 1'b0;
            div_q        <= '0;
            warm_cnt     <= '0;
            hold_nib     <= 4'h0;
            pack_flag    <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        div_q        <= cfg_div;
                        warm_cnt     <= WARM_W'(WARMUP);
                        pack_flag    <= 1'b0;
                        overflow     <= 1'b0;
                        block_enable <= 1'b1;
                        state        <= (WARMUP == 0) ? S_RUN : S_WARMUP;
                    end
                end
                S_WARMUP: begin
                    if (stop) begin
                        block_enable <= 1'b0;
                        state        <= S_IDLE;
                    end else if (enc_valid) begin
                        if (warm_cnt == WARM_W'(1)) begin
                            state <= S_RUN;
                        end else begin
                            warm_cnt <= warm_cnt - WARM_W'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (enc_valid) begin
                        if (pack_flag) begin
                            pack_flag <= 1'b0;
                        end else begin
                            hold_nib  <= enc_pcm;
                            pack_flag <= 1'b1;
                        end
                    end
                    if (stop) begin
                        block_enable <= 1'b0;
                        state        <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pack_flag) begin
                        pack_flag <= 1'b0;
                    end else if (fifo_empty) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    block_enable <= 1'b0;
                    state        <= S_IDLE;
                end
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Tick and decimation timers are down-counters reloaded at terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            dec_cnt  <= '0;
        end else if (start_go) begin
            tick_cnt <= cfg_div;
            dec_cnt  <= DEC_W'(DECIM - 1);
        end else if (block_enable) begin
            if (tick_cnt == '0) begin
                tick_cnt <= div_q;
                if (dec_cnt == '0) begin
                    dec_cnt <= DEC_W'(DECIM - 1);
                end else begin
                    dec_cnt <= dec_cnt - DEC_W'(1);
                end
            end else begin
                tick_cnt <= tick_cnt - DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_byte;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_adpcm_stream_ctrl.sv
// Directed bench for adpcm_stream_ctrl: expected bytes are queued as nibbles are
// driven and checked against the byte port when the consumer accepts them.
module tb_adpcm_stream_ctrl;

    localparam int DECIM      = 4;
    localparam int WARMUP     = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int DIV_W      = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [DIV_W-1:0] cfg_div = '0;
    logic             enc_valid = 1'b0;
    logic [3:0]       enc_pcm = 4'h0;
    logic             byte_ready = 1'b0;
    logic             pdm_clk_en;
    logic             dec_strobe;
    logic             block_enable;
    logic [7:0]       byte_data;
    logic             byte_valid;
    logic             overflow;
    logic             busy;

    int         n_cmp = 0;
    int         n_fail = 0;
    logic [7:0] exp_q [$];
    int         m_warm = 0;
    logic       m_flag = 1'b0;
    logic [3:0] m_hold = 4'h0;
    logic       m_ovf = 1'b0;
    logic       bp_mode = 1'b0;
    logic       stall_q = 1'b0;
    logic [7:0] stall_data = 8'h00;
    logic [7:0] mon_exp;

    adpcm_stream_ctrl #(
        .DECIM(DECIM), .WARMUP(WARMUP), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cfg_div(cfg_div),
        .pdm_clk_en(pdm_clk_en), .dec_strobe(dec_strobe), .block_enable(block_enable),
        .enc_valid(enc_valid), .enc_pcm(enc_pcm), .byte_data(byte_data),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .overflow(overflow), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Consumer side: every accepted byte must be the oldest expected one, and a
    // stalled head must not change.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q <= 1'b0;
        end else begin
            if (stall_q && byte_valid) check("stall_hold", 32'(byte_data), 32'(stall_data));
            if (byte_valid && byte_ready) begin
                check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    check("byte_data", 32'(byte_data), 32'(mon_exp));
                end
            end
            stall_q    <= byte_valid && !byte_ready;
            stall_data <= byte_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp_mode) byte_ready = ~byte_ready;
    endtask

    task automatic push_exp(input logic [7:0] b);
        if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(b);
        else m_ovf = 1'b1;
    endtask

    task automatic send_nib(input logic [3:0] n);
        enc_pcm   = n;
        enc_valid = 1'b1;
        if (m_warm > 0) begin
            m_warm--;
        end else if (!m_flag) begin
            m_hold = n;
            m_flag = 1'b1;
        end else begin
            push_exp({m_hold, n});
            m_flag = 1'b0;
        end
        tick();
        enc_valid = 1'b0;
    endtask

    task automatic do_start(input logic [DIV_W-1:0] div);
        start   = 1'b1;
        cfg_div = div;
        m_warm  = WARMUP;
        m_flag  = 1'b0;
        m_ovf   = 1'b0;
        tick();
        start = 1'b0;
        check("start_block_enable", 32'(block_enable), 32'd1);
        check("start_busy", 32'(busy), 32'd1);
    endtask

    task automatic do_stop_run();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        if (m_flag) begin
            push_exp({m_hold, 4'h0});
            m_flag = 1'b0;
        end
        check("drain_block_enable", 32'(block_enable), 32'd0);
        check("drain_busy", 32'(busy), 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (!busy) break;
            tick();
        end
        check("idle_busy", 32'(busy), 32'd0);
        check("all_bytes_out", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        // reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_byte_valid", 32'(byte_valid), 32'd0);
        check("rst_byte_data", 32'(byte_data), 32'd0);
        check("rst_block_enable", 32'(block_enable), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_pdm_clk_en", 32'(pdm_clk_en), 32'd0);
        check("rst_dec_strobe", 32'(dec_strobe), 32'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // tick and decimation timing, cfg_div=1
        byte_ready = 1'b1;
        do_start(8'd1);
        for (int k = 1; k <= 16; k++) begin
            check($sformatf("pdm_clk_en_c%0d", k), 32'(pdm_clk_en), 32'((k % 2) == 0));
            check($sformatf("dec_strobe_c%0d", k), 32'(dec_strobe), 32'((k % 8) == 0));
            tick();
        end

        // warm-up discard and packing
        for (int i = 1; i <= 6; i++) send_nib(4'(i));
        repeat (3) tick();
        check("run_overflow", 32'(overflow), 32'(m_ovf));
        do_stop_run();
        wait_idle();

        // odd nibble count flushes a zero-padded byte; DRAIN ignores enc_valid
        do_start(8'd0);
        send_nib(4'hA);
        send_nib(4'hB);
        send_nib(4'h3);
        send_nib(4'h4);
        send_nib(4'h9);
        do_stop_run();
        enc_pcm   = 4'h7;
        enc_valid = 1'b1;
        tick();
        enc_valid = 1'b0;
        wait_idle();

        // start and stop together: start wins; stop in WARMUP returns to IDLE
        start   = 1'b1;
        stop    = 1'b1;
        cfg_div = 8'd3;
        m_warm  = WARMUP;
        m_flag  = 1'b0;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("start_stop_busy", 32'(busy), 32'd1);
        send_nib(4'h5);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("warm_stop_busy", 32'(busy), 32'd0);
        check("warm_stop_block_enable", 32'(block_enable), 32'd0);
        check("warm_stop_pdm", 32'(pdm_clk_en), 32'd0);

        // overflow with a stalled consumer
        byte_ready = 1'b0;
        do_start(8'd2);
        send_nib(4'h0);
        send_nib(4'h0);
        for (int i = 0; i < 10; i++) send_nib(4'((i * 3 + 1) & 15));
        tick();
        check("ovf_overflow", 32'(overflow), 32'(m_ovf));
        check("ovf_expected_flag", 32'(m_ovf), 32'd1);
        check("ovf_byte_valid", 32'(byte_valid), 32'd1);
        do_stop_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("drain_start_ignored_be", 32'(block_enable), 32'd0);
        check("drain_start_ignored_busy", 32'(busy), 32'd1);
        byte_ready = 1'b1;
        wait_idle();
        check("ovf_sticky", 32'(overflow), 32'd1);
        do_start(8'd0);
        check("ovf_cleared_by_start", 32'(overflow), 32'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // backpressure: ready toggles every cycle
        bp_mode    = 1'b1;
        byte_ready = 1'b1;
        do_start(8'd1);
        send_nib(4'h0);
        send_nib(4'h0);
        for (int i = 0; i < 12; i++) send_nib(4'((i * 5 + 3) & 15));
        do_stop_run();
        wait_idle();
        check("bp_overflow", 32'(overflow), 32'(m_ovf));
        bp_mode    = 1'b0;
        byte_ready = 1'b1;

        // asynchronous reset mid-RUN with two bytes buffered
        byte_ready = 1'b0;
        do_start(8'd0);
        send_nib(4'h0);
        send_nib(4'h0);
        send_nib(4'h1);
        send_nib(4'h2);
        send_nib(4'h3);
        send_nib(4'h4);
        tick();
        check("pre_rst_byte_valid", 32'(byte_valid), 32'd1);
        check("pre_rst_pdm", 32'(pdm_clk_en), 32'd1);
        #2 rst_n = 1'b0;
        exp_q.delete();
        m_flag = 1'b0;
        #1;
        check("arst_byte_valid", 32'(byte_valid), 32'd0);
        check("arst_block_enable", 32'(block_enable), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_overflow", 32'(overflow), 32'd0);
        check("arst_pdm", 32'(pdm_clk_en), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick();
        byte_ready = 1'b1;
        do_start(8'd1);
        send_nib(4'h0);
        send_nib(4'h0);
        send_nib(4'hC);
        send_nib(4'hD);
        send_nib(4'hE);
        do_stop_run();
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
